// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the framed instruction-memory loader.
// State encoding, default frame start byte and instruction word width.
package boot_loader_pkg;

  localparam int unsigned REG_W = 32;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/boot_loader.sv
// Receives a framed byte stream and writes 32-bit words into instruction RAM,
// holding the core in reset until a frame passes its checksum.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 100000,
  parameter logic [7:0]  SYNC    = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [REG_W-1:0]  mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  state_e             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic [15:0]        len_q, len_d;
  logic [7:0]         csum_q, csum_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [REG_W-1:0]   wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               core_rst_q, core_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        len_n;

  assign len_n = {rx_data, len_q[7:0]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    tmo_d      = '0;

    // Address advances once the previous write pulse has been presented;
    // the final word leaves DATA, so the address never steps past the frame.
    if (we_q && state_q == ST_DATA) addr_d = addr_q + ADDR_W'(1);

    if (is_busy(state_q) && !rx_valid) tmo_d = tmo_q + TMO_W'(1);

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (rx_valid && rx_data == SYNC) begin
          state_d    = ST_LEN_LO;
          csum_d     = '0;
          addr_d     = '0;
          byte_cnt_d = '0;
          word_cnt_d = '0;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          len_d = len_n;
          if (len_n == '0)                  state_d = ST_CSUM;
          else if ({16'd0, len_n} > DEPTH)  state_d = ST_ERR;
          else                              state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          csum_d     = csum_q + rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == len_q) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (rx_valid) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase

    if (is_busy(state_q) && !rx_valid && tmo_q == TMO_W'(TIMEOUT - 1)) state_d = ST_ERR;

    // Status flags are registered so the core reset line is glitch-free.
    core_rst_d = (state_d == ST_DONE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
    busy_d     = is_busy(state_d);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      core_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_rst  = core_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed and random frames compared
// against a frame-parsing reference model.
module tb_boot_loader;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef wr_t wrq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;
  wrq_t got;

  boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write capture, sampled mid-cycle; a pulse longer than one cycle shows up twice.
  always @(negedge clk) begin
    if (rst && mem_we) got.push_back('{addr: 32'(mem_addr), data: mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bytes_t f, input bit b2b);
    for (int i = 0; i < f.size(); i++) begin
      rx_data  = f[i];
      rx_valid = 1'b1;
      tick(1);
      if (!b2b) begin
        rx_valid = 1'b0;
        tick($urandom_range(0, 3));
      end
    end
    rx_valid = 1'b0;
  endtask

  function automatic bytes_t make_frame(input int n, input bit bad);
    bytes_t f;
    logic [7:0] sum = '0;
    logic [7:0] b;
    f.push_back(8'hA5);
    f.push_back(8'(n));
    f.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      sum += b;
      f.push_back(b);
    end
    f.push_back(bad ? sum + 8'd1 : sum);
    return f;
  endfunction

  // Reference: parse a complete frame directly from the frame format rules.
  task automatic model(input bytes_t f, output wrq_t w, output bit ok, output bit bad);
    int n;
    int sum;
    w.delete();
    n = int'(f[1]) + 256 * int'(f[2]);
    ok = 1'b0;
    bad = 1'b0;
    if (n > int'(DEPTH)) begin
      bad = 1'b1;
      return;
    end
    sum = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] d = '0;
      for (int k = 0; k < 4; k++) begin
        d = d | (32'(f[3 + 4 * i + k]) << (8 * k));
        sum = sum + int'(f[3 + 4 * i + k]);
      end
      w.push_back('{addr: 32'(i), data: d});
    end
    ok  = ((sum % 256) == int'(f[3 + 4 * n]));
    bad = !ok;
  endtask

  task automatic run_frame(input string tag, input bytes_t f, input bit b2b);
    wrq_t exp;
    bit ok, bad;
    int m;
    got.delete();
    send(f, b2b);
    tick(3);
    model(f, exp, ok, bad);
    check({tag, ".nwr"}, 32'(got.size()), 32'(exp.size()));
    m = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s.addr%0d", tag, i), got[i].addr, exp[i].addr);
      check($sformatf("%s.data%0d", tag, i), got[i].data, exp[i].data);
    end
    check({tag, ".done"}, 32'(done), 32'(ok));
    check({tag, ".err"}, 32'(err), 32'(bad));
    check({tag, ".core_rst"}, 32'(core_rst), 32'(ok));
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".we"}, 32'(mem_we), 32'd0);
    check({tag, ".addr"}, 32'(mem_addr), 32'd0);
    check({tag, ".wdata"}, mem_wdata, 32'd0);
    check({tag, ".core_rst"}, 32'(core_rst), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
  endtask

  initial begin
    bytes_t f;

    // Reset state.
    #2;
    check_reset_values("reset");
    tick(2);
    rst = 1'b1;
    tick(2);
    check_reset_values("idle");

    // Known two-word program, good and bad checksum.
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    run_frame("t1", f, 1'b0);
    f[11] = 8'hB7;
    run_frame("t2", f, 1'b0);

    // Empty frame, then a new SYNC drops the core back into reset.
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("t3", f, 1'b0);
    got.delete();
    send('{8'hA5}, 1'b1);
    check("t3.sync.core_rst", 32'(core_rst), 32'd0);
    check("t3.sync.busy", 32'(busy), 32'd1);

    // Oversized length aborts right after the high length byte.
    send('{8'(DEPTH + 1), 8'((DEPTH + 1) >> 8)}, 1'b1);
    check("t4.err", 32'(err), 32'd1);
    check("t4.busy", 32'(busy), 32'd0);
    tick(2);
    check("t4.nwr", 32'(got.size()), 32'd0);
    // Largest legal frame fills every word.
    run_frame("t4max", make_frame(DEPTH, 1'b0), 1'b1);

    // Stall mid-frame: alive well before the limit, aborted after it.
    got.delete();
    send('{8'hA5, 8'h02, 8'h00, 8'h13}, 1'b0);
    tick(TIMEOUT / 2);
    check("t5.alive.err", 32'(err), 32'd0);
    check("t5.alive.busy", 32'(busy), 32'd1);
    tick(TIMEOUT);
    check("t5.err", 32'(err), 32'd1);
    check("t5.busy", 32'(busy), 32'd0);
    check("t5.nwr", 32'(got.size()), 32'd0);
    run_frame("t5.next", make_frame(3, 1'b0), 1'b0);

    // Random frames with random gaps and occasional bad checksums.
    for (int i = 0; i < 6; i++)
      run_frame($sformatf("rnd%0d", i),
                make_frame($urandom_range(1, 8), ($urandom_range(0, 3) == 0)), 1'b0);

    // Back-to-back 16-word frame.
    run_frame("t6", make_frame(16, 1'b0), 1'b1);

    // Async reset in the middle of DATA.
    f = make_frame(16, 1'b0);
    f = f[0:12];
    send(f, 1'b1);
    check("t6.mid.busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("t6.rst");
    tick(2);
    rst = 1'b1;
    tick(1);
    run_frame("t6.after", make_frame(2, 1'b0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
